// File: rtl/ttt_game_sequencer.sv
// ttt_game_sequencer: tic-tac-toe sequencer with cursor control, a
// one-line-per-cycle win/draw checker and an optional computer opponent
// playing O. Define TTT_AI_EN to build the AI_SCAN/AI_COMMIT opponent;
// without it both players place through cmd.
module ttt_game_sequencer #(
  parameter logic [1:0] START_PLAYER = 2'b01
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  output logic [1:0]  cursor_col,
  output logic [1:0]  cursor_row,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [1:0]  winner,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_AI_SCAN   = 3'd2,
    S_AI_COMMIT = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  localparam logic [2:0] CMD_RIGHT = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_UP    = 3'd3;
  localparam logic [2:0] CMD_PLACE = 3'd4;
  localparam logic [2:0] CMD_NEW   = 3'd5;

  localparam logic [1:0] P_EMPTY = 2'b00;
  localparam logic [1:0] P_X     = 2'b01;
  localparam logic [1:0] P_O     = 2'b10;
  localparam logic [1:0] P_DRAW  = 2'b11;

  // Cell k lives at bits [17-2k:16-2k]; shift that puts it at [1:0].
  function automatic logic [4:0] cell_shift(input logic [3:0] k);
    return 5'd16 - {k, 1'b0};
  endfunction

  function automatic logic [1:0] cell_get(input logic [17:0] b, input logic [3:0] k);
    logic [17:0] t;
    t = b >> cell_shift(k);
    return t[1:0];
  endfunction

  function automatic logic [17:0] cell_put(input logic [17:0] b, input logic [3:0] k,
                                           input logic [1:0] v);
    return (b & ~(18'h3 << cell_shift(k))) | ({16'd0, v} << cell_shift(k));
  endfunction

  // Three cell indices of line li: rows 0-2, columns 3-5, diagonal, anti-diagonal.
  function automatic logic [11:0] line_cells(input logic [2:0] li);
    case (li)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  scan_idx_q, scan_idx_d;
  logic        found_q, found_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  turn_q, turn_d;
  logic [1:0]  winner_q, winner_d;
  logic        busy_q, busy_d;

  logic [11:0] line_w;
  logic [3:0]  lc0, lc1, lc2;
  logic [1:0]  lv0, lv1, lv2;
  logic        line_mover;
  logic        board_full;
  logic [3:0]  cur_cell;
  logic        human_ok;

`ifdef TTT_AI_EN
  localparam logic [3:0] AI_PRI [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};

  // {hit, cell}: line holds two of p and one empty cell.
  function automatic logic [4:0] pair_find(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c, input logic [3:0] ka,
                                           input logic [3:0] kb, input logic [3:0] kc,
                                           input logic [1:0] p);
    if (a == P_EMPTY && b == p && c == p) return {1'b1, ka};
    if (a == p && b == P_EMPTY && c == p) return {1'b1, kb};
    if (a == p && b == p && c == P_EMPTY) return {1'b1, kc};
    return 5'd0;
  endfunction

  logic        win_vld_q, win_vld_d;
  logic [3:0]  win_cell_q, win_cell_d;
  logic        blk_vld_q, blk_vld_d;
  logic [3:0]  blk_cell_q, blk_cell_d;
  logic [4:0]  o_pair, x_pair;
  logic [3:0]  fb_cell, ai_cell;
  logic        fb_found;

  // Candidate detection on the current line and final choice of the O move
  always_comb begin
    o_pair   = pair_find(lv0, lv1, lv2, lc0, lc1, lc2, P_O);
    x_pair   = pair_find(lv0, lv1, lv2, lc0, lc1, lc2, P_X);
    fb_cell  = 4'd0;
    fb_found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!fb_found && cell_get(board_q, AI_PRI[i]) == P_EMPTY) begin
        fb_cell  = AI_PRI[i];
        fb_found = 1'b1;
      end
    end
    if (win_vld_q)      ai_cell = win_cell_q;
    else if (blk_vld_q) ai_cell = blk_cell_q;
    else                ai_cell = fb_cell;
  end
`endif

  // Decode the line addressed by the scan index and summarise the board
  always_comb begin
    line_w     = line_cells(scan_idx_q);
    lc0        = line_w[11:8];
    lc1        = line_w[7:4];
    lc2        = line_w[3:0];
    lv0        = cell_get(board_q, lc0);
    lv1        = cell_get(board_q, lc1);
    lv2        = cell_get(board_q, lc2);
    line_mover = (lv0 == turn_q) && (lv1 == turn_q) && (lv2 == turn_q);
    board_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board_q[2*i +: 2] == P_EMPTY) board_full = 1'b0;
    end
    cur_cell = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};
`ifdef TTT_AI_EN
    human_ok = (turn_q == P_X);
`else
    human_ok = 1'b1;
`endif
  end

  // Next-state logic for the game sequencer
  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    found_d    = found_q;
    board_d    = board_q;
    col_d      = col_q;
    row_d      = row_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
`ifdef TTT_AI_EN
    win_vld_d  = win_vld_q;
    win_cell_d = win_cell_q;
    blk_vld_d  = blk_vld_q;
    blk_cell_d = blk_cell_q;
`endif

    case (state_q)
      S_IDLE, S_OVER: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_RIGHT: if (col_q != 2'd2) col_d = col_q + 2'd1;
            CMD_LEFT:  if (col_q != 2'd0) col_d = col_q - 2'd1;
            CMD_DOWN:  if (row_q != 2'd2) row_d = row_q + 2'd1;
            CMD_UP:    if (row_q != 2'd0) row_d = row_q - 2'd1;
            CMD_PLACE: begin
              if (state_q == S_IDLE && winner_q == P_EMPTY &&
                  cell_get(board_q, cur_cell) == P_EMPTY && human_ok) begin
                board_d    = cell_put(board_q, cur_cell, turn_q);
                state_d    = S_CHECK;
                scan_idx_d = 3'd0;
                found_d    = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end

      S_CHECK: begin
        if (scan_idx_q == 3'd7) begin
          scan_idx_d = 3'd0;
          found_d    = 1'b0;
          if (found_q || line_mover) begin
            winner_d = turn_q;
            state_d  = S_OVER;
          end else if (board_full) begin
            winner_d = P_DRAW;
            state_d  = S_OVER;
          end else begin
            turn_d = (turn_q == P_X) ? P_O : P_X;
`ifdef TTT_AI_EN
            if (turn_q == P_X) begin
              state_d    = S_AI_SCAN;
              win_vld_d  = 1'b0;
              win_cell_d = 4'd0;
              blk_vld_d  = 1'b0;
              blk_cell_d = 4'd0;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end
        end else begin
          found_d    = found_q | line_mover;
          scan_idx_d = scan_idx_q + 3'd1;
        end
      end

`ifdef TTT_AI_EN
      S_AI_SCAN: begin
        // Only the lowest-index qualifying line is kept.
        if (!win_vld_q && o_pair[4]) begin
          win_vld_d  = 1'b1;
          win_cell_d = o_pair[3:0];
        end
        if (!blk_vld_q && x_pair[4]) begin
          blk_vld_d  = 1'b1;
          blk_cell_d = x_pair[3:0];
        end
        if (scan_idx_q == 3'd7) begin
          scan_idx_d = 3'd0;
          state_d    = S_AI_COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + 3'd1;
        end
      end

      S_AI_COMMIT: begin
        board_d    = cell_put(board_q, ai_cell, P_O);
        state_d    = S_CHECK;
        scan_idx_d = 3'd0;
        found_d    = 1'b0;
        win_vld_d  = 1'b0;
        blk_vld_d  = 1'b0;
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // New game wins over everything, including an in-flight scan.
    if (cmd_valid && cmd == CMD_NEW) begin
      state_d    = S_IDLE;
      scan_idx_d = 3'd0;
      found_d    = 1'b0;
      board_d    = 18'd0;
      col_d      = 2'd0;
      row_d      = 2'd0;
      turn_d     = START_PLAYER;
      winner_d   = P_EMPTY;
`ifdef TTT_AI_EN
      win_vld_d  = 1'b0;
      win_cell_d = 4'd0;
      blk_vld_d  = 1'b0;
      blk_cell_d = 4'd0;
`endif
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      scan_idx_q <= 3'd0;
      found_q    <= 1'b0;
      board_q    <= 18'd0;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      turn_q     <= START_PLAYER;
      winner_q   <= P_EMPTY;
      busy_q     <= 1'b0;
`ifdef TTT_AI_EN
      win_vld_q  <= 1'b0;
      win_cell_q <= 4'd0;
      blk_vld_q  <= 1'b0;
      blk_cell_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      found_q    <= found_d;
      board_q    <= board_d;
      col_q      <= col_d;
      row_q      <= row_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      busy_q     <= busy_d;
`ifdef TTT_AI_EN
      win_vld_q  <= win_vld_d;
      win_cell_q <= win_cell_d;
      blk_vld_q  <= blk_vld_d;
      blk_cell_q <= blk_cell_d;
`endif
    end
  end

  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign board      = board_q;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ttt_game_sequencer.sv
// tb_ttt_game_sequencer: cursor vector table plus hand-written game
// sequences; expected output tuples go through a scoreboard queue.
module tb_ttt_game_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cursor_col, cursor_row, turn, winner;
  logic [17:0] board;
  logic        busy;

  ttt_game_sequencer #(.START_PLAYER(2'b01)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .board     (board),
    .turn      (turn),
    .winner    (winner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [26:0] want;
  } exp_t;

  typedef struct {
    logic [2:0] c;
    logic [1:0] col;
    logic [1:0] row;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0]  m_col, m_row, m_turn, m_win;
  logic [17:0] m_board;

  function automatic logic [26:0] dut_vec();
    return {cursor_col, cursor_row, board, turn, winner, busy};
  endfunction

  task automatic chk(input string nm, input logic [26:0] got, input logic [26:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("check %-16s ok   col=%0d row=%0d board=%05h turn=%b win=%b busy=%b",
               nm, got[26:25], got[24:23], got[22:5], got[4:3], got[2:1], got[0]);
    end else begin
      $display("FAIL %-16s got col=%0d row=%0d board=%05h turn=%b win=%b busy=%b | want col=%0d row=%0d board=%05h turn=%b win=%b busy=%b",
               nm, got[26:25], got[24:23], got[22:5], got[4:3], got[2:1], got[0],
               want[26:25], want[24:23], want[22:5], want[4:3], want[2:1], want[0]);
    end
  endtask

  task automatic push_exp(input string nm, input logic bsy);
    exp_t e;
    e.name = nm;
    e.want = {m_col, m_row, m_board, m_turn, m_win, bsy};
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty got nothing queued, want one entry");
    end else begin
      e = sb_q.pop_front();
      chk(e.name, dut_vec(), e.want);
    end
  endtask

  task automatic send(input logic [2:0] c);
    @(negedge clk);
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_col   = 2'd0;
    m_row   = 2'd0;
    m_board = 18'd0;
    m_turn  = 2'b01;
    m_win   = 2'b00;
  endtask

  task automatic do_cursor(input logic [2:0] c, input string nm);
    case (c)
      3'd0: if (m_col != 2'd2) m_col = m_col + 2'd1;
      3'd1: if (m_col != 2'd0) m_col = m_col - 2'd1;
      3'd2: if (m_row != 2'd2) m_row = m_row + 2'd1;
      3'd3: if (m_row != 2'd0) m_row = m_row - 2'd1;
      default: ;
    endcase
    push_exp(nm, 1'b0);
    send(c);
    pop_check();
  endtask

  task automatic move_to(input logic [1:0] r, input logic [1:0] c);
    while (m_col < c) do_cursor(3'd0, "mv_right");
    while (m_col > c) do_cursor(3'd1, "mv_left");
    while (m_row < r) do_cursor(3'd2, "mv_down");
    while (m_row > r) do_cursor(3'd3, "mv_up");
  endtask

  task automatic new_game(input string nm);
    model_reset();
    push_exp(nm, 1'b0);
    send(3'd5);
    pop_check();
  endtask

  task automatic set_cell(input int k, input logic [1:0] v);
    m_board[17-2*k -: 2] = v;
  endtask

  // Accepted place: the cell shows the mover right after the accepting edge.
  task automatic place_start(input string nm);
    set_cell(int'(m_row) * 3 + int'(m_col), m_turn);
    push_exp(nm, 1'b1);
    send(3'd4);
    pop_check();
  endtask

  task automatic wait_done(input string nm, input int n_mid, input logic [1:0] exp_win);
    logic all_busy;
    all_busy = 1'b1;
    repeat (n_mid) begin
      @(posedge clk);
      #1;
      all_busy &= busy;
    end
    chk({nm, "_busy"}, {26'd0, all_busy}, 27'd1);
    @(posedge clk);
    #1;
    if (exp_win != 2'b00) m_win = exp_win;
    else m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
    push_exp(nm, 1'b0);
    pop_check();
  endtask

  task automatic place(input logic [1:0] r, input logic [1:0] c,
                       input logic [1:0] exp_win, input string nm);
    move_to(r, c);
    place_start(nm);
    wait_done(nm, 7, exp_win);
  endtask

  // X places at (r,c); O is expected at ai_k on edge N+17, busy low after N+25.
  task automatic ai_round(input logic [1:0] r, input logic [1:0] c,
                          input int ai_k, input string nm);
    logic ok;
    move_to(r, c);
    place_start(nm);
    ok = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1;
      ok &= busy & (board === m_board);
    end
    chk({nm, "_scan"}, {26'd0, ok}, 27'd1);
    @(posedge clk);
    #1;
    set_cell(ai_k, 2'b10);
    m_turn = 2'b10;
    push_exp({nm, "_ai"}, 1'b1);
    pop_check();
    wait_done({nm, "_fin"}, 7, 2'b00);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_hold", 1'b0);
    pop_check();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_exp("reset_release", 1'b0);
    pop_check();

    // Cursor table: cmd, expected col, expected row.
    vecs[0]  = '{3'd0, 2'd1, 2'd0};
    vecs[1]  = '{3'd0, 2'd2, 2'd0};
    vecs[2]  = '{3'd0, 2'd2, 2'd0};
    vecs[3]  = '{3'd1, 2'd1, 2'd0};
    vecs[4]  = '{3'd3, 2'd1, 2'd0};
    vecs[5]  = '{3'd2, 2'd1, 2'd1};
    vecs[6]  = '{3'd2, 2'd1, 2'd2};
    vecs[7]  = '{3'd2, 2'd1, 2'd2};
    vecs[8]  = '{3'd6, 2'd1, 2'd2};
    vecs[9]  = '{3'd7, 2'd1, 2'd2};
    vecs[10] = '{3'd1, 2'd0, 2'd2};
    vecs[11] = '{3'd1, 2'd0, 2'd2};
    vecs[12] = '{3'd3, 2'd0, 2'd1};
    vecs[13] = '{3'd3, 2'd0, 2'd0};
    for (int i = 0; i < 14; i++) begin
      m_col = vecs[i].col;
      m_row = vecs[i].row;
      push_exp($sformatf("vec%0d_cmd%0d", i, vecs[i].c), 1'b0);
      send(vecs[i].c);
      pop_check();
    end

`ifndef TTT_AI_EN
    // X wins along row 0 with O on cells 3 and 4 in between.
    new_game("ng_win");
    place(2'd0, 2'd0, 2'b00, "x_c0");
    place(2'd1, 2'd0, 2'b00, "o_c3");
    place(2'd0, 2'd1, 2'b00, "x_c1");
    place(2'd1, 2'd1, 2'b00, "o_c4");
    place(2'd0, 2'd2, 2'b01, "x_c2_win");
    move_to(2'd1, 2'd2);
    push_exp("over_place", 1'b0);
    send(3'd4);
    pop_check();

    // Full board without a line ends in a draw.
    new_game("ng_draw");
    place(2'd0, 2'd0, 2'b00, "d_x0");
    place(2'd0, 2'd1, 2'b00, "d_o1");
    place(2'd0, 2'd2, 2'b00, "d_x2");
    place(2'd1, 2'd1, 2'b00, "d_o4");
    place(2'd1, 2'd0, 2'b00, "d_x3");
    place(2'd1, 2'd2, 2'b00, "d_o5");
    place(2'd2, 2'd1, 2'b00, "d_x7");
    place(2'd2, 2'd0, 2'b00, "d_o6");
    place(2'd2, 2'd2, 2'b11, "d_x8_draw");

    // Commands while busy are dropped; place on an occupied cell is ignored.
    new_game("ng_busy");
    place_start("b_x0");
    push_exp("busy_right", 1'b1);
    send(3'd0);
    pop_check();
    push_exp("busy_place", 1'b1);
    send(3'd4);
    pop_check();
    wait_done("b_x0", 5, 2'b00);
    push_exp("occupied_place", 1'b0);
    send(3'd4);
    pop_check();

    // New game in the middle of CHECK clears everything at once.
    do_cursor(3'd0, "nc_right");
    place_start("nc_o1");
    repeat (2) @(posedge clk);
    new_game("ng_in_check");
`else
    new_game("ng_ai_center");
    ai_round(2'd1, 2'd1, 0, "ai_x4");
    new_game("ng_ai_block");
    ai_round(2'd0, 2'd0, 4, "ai_x0");
    ai_round(2'd0, 2'd1, 2, "ai_x1_block");
`endif

    // Asynchronous reset during CHECK takes effect without a clock edge.
    new_game("ng_async");
    place_start("ar_x0");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    push_exp("async_reset", 1'b0);
    pop_check();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_exp("after_reset", 1'b0);
    pop_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
